// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Package: nibble_serial_adder_ctrl_pkg
// Purpose: Shared definitions for the nibble-serial adder sequencer. The
//          calculator top level uses the same state encoding.
// Contents:
//   state_t  - FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   STATE_W  - width of the state encoding
//   NIBBLE_W - width of one adder slice
package nibble_serial_adder_ctrl_pkg;

  localparam int STATE_W  = 2;
  localparam int NIBBLE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FullAdder_4bit.sv
// Module: FullAdder_4bit
// Purpose: 4-bit ripple-carry adder shared by the calculator datapath.
// Ports:
//   a, b  in  4  addends
//   cin   in  1  carry in
//   sum   out 4  a + b + cin, modulo 16
//   cout  out 1  carry out of bit 3
module FullAdder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry_chain;

  assign carry_chain[0] = cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign sum[gi]           = a[gi] ^ b[gi] ^ carry_chain[gi];
      assign carry_chain[gi+1] = (a[gi] & b[gi]) | (carry_chain[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry_chain[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Module: nibble_serial_adder_ctrl
// Purpose: Sequences a wide add/subtract through the shared 4-bit adder, one
//          nibble per cycle, least-significant nibble first, with a
//          start/busy/done handshake.
// Parameters:
//   N_NIBBLES  operand width in nibbles (2..8); W = 4*N_NIBBLES
// Ports:
//   i_clk       in   1  system clock, rising edge
//   i_rst_n     in   1  asynchronous active-low reset
//   i_start     in   1  request, only looked at in IDLE
//   i_op_sub    in   1  0 = A+B, 1 = A-B, captured with i_start
//   i_A, i_B    in   W  operands, captured with i_start
//   o_busy      out  1  high in RUN and DONE
//   o_done      out  1  one-cycle pulse, results valid from this cycle on
//   o_result    out  W  sum/difference, held until the next accepted start
//   o_carry     out  1  carry out of the top nibble (sub: 1 = no borrow)
//   o_overflow  out  1  two's-complement signed overflow
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_op_sub,
  input  logic [4*N_NIBBLES-1:0]    i_A,
  input  logic [4*N_NIBBLES-1:0]    i_B,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [4*N_NIBBLES-1:0]    o_result,
  output logic                      o_carry,
  output logic                      o_overflow
);

  localparam int W     = NIBBLE_W * N_NIBBLES;
  localparam int IDX_W = $clog2(N_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  state_t           state_reg,    state_next;
  logic [W-1:0]     op_a_reg,     op_a_next;
  logic [W-1:0]     op_b_reg,     op_b_next;
  logic             c_reg,        c_next;
  logic [IDX_W-1:0] idx_reg,      idx_next;
  logic [W-1:0]     result_reg,   result_next;
  logic             carry_reg,    carry_next;
  logic             overflow_reg, overflow_next;

  // Nibble views of the operands, selected by idx_reg for the shared adder.
  logic [NIBBLE_W-1:0] a_nib [N_NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [N_NIBBLES];
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;
  // Current result with the nibble at idx_reg replaced by the adder output.
  logic [W-1:0]        result_wr;

  generate
    for (genvar gi = 0; gi < N_NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = op_a_reg[NIBBLE_W*gi +: NIBBLE_W];
      assign b_nib[gi] = op_b_reg[NIBBLE_W*gi +: NIBBLE_W];
      assign result_wr[NIBBLE_W*gi +: NIBBLE_W] =
        (idx_reg == IDX_W'(gi)) ? add_sum : result_reg[NIBBLE_W*gi +: NIBBLE_W];
    end
  endgenerate

  FullAdder_4bit u_add (
    .a    (a_nib[idx_reg]),
    .b    (b_nib[idx_reg]),
    .cin  (c_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      c_reg        <= 1'b0;
      idx_reg      <= '0;
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
      c_reg        <= c_next;
      idx_reg      <= idx_next;
      result_reg   <= result_next;
      carry_reg    <= carry_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_a_next     = op_a_reg;
    op_b_next     = op_b_reg;
    c_next        = c_reg;
    idx_next      = idx_reg;
    result_next   = result_reg;
    carry_next    = carry_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
          op_a_next     = i_A;
          op_b_next     = i_op_sub ? ~i_B : i_B;
          c_next        = i_op_sub;
          idx_next      = '0;
          result_next   = '0;
          carry_next    = 1'b0;
          overflow_next = 1'b0;
          state_next    = ST_RUN;
        end
      end

      ST_RUN: begin
        result_next = result_wr;
        c_next      = add_cout;
        if (idx_reg == LAST_IDX) begin
          // Signed overflow: like-signed addends giving a result of the other sign.
          carry_next    = add_cout;
          overflow_next = (op_a_reg[W-1] == op_b_reg[W-1]) &&
                          (add_sum[NIBBLE_W-1] != op_a_reg[W-1]);
          state_next    = ST_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy     = (state_reg != ST_IDLE);
  assign o_done     = (state_reg == ST_DONE);
  assign o_result   = result_reg;
  assign o_carry    = carry_reg;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;

  int checks;
  int errors;

  nibble_serial_adder_ctrl #(.N_NIBBLES(N)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_op_sub   (op_sub),
    .i_A        (a),
    .i_B        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_carry    (carry),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, carry = no-borrow for subtraction,
  // overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sub);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    if (sub) begin
      r = x - y;
      c = (x >= y);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      wide = {1'b0, x} + {1'b0, y};
      r = wide[W-1:0];
      c = wide[W];
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {c, v, r};
  endfunction

  // Starts one op after a negedge, drops start after the accept edge, then
  // waits for done. lat = negedges from start assertion to done observed.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                        output int lat);
    @(negedge clk);
    start  = 1'b1;
    op_sub = sub;
    a      = x;
    b      = y;
    lat    = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (done) break;
      if (lat > 20) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: waited %0d cycles, required done within 20", lat);
        break;
      end
    end
  endtask

  task automatic check_res(input string name, input logic [W-1:0] r_exp,
                           input logic c_exp, input logic v_exp);
    checks++;
    if (result !== r_exp || carry !== c_exp || overflow !== v_exp) begin
      errors++;
      $display("FAIL %s: got result=%h carry=%b ovf=%b, required result=%h carry=%b ovf=%b",
               name, result, carry, overflow, r_exp, c_exp, v_exp);
    end
    $display("op %s: result=%h carry=%b ovf=%b", name, result, carry, overflow);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, carry, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h carry=%b ovf=%b, required all 0",
               busy, done, result, carry, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b, required 0", busy);
    end
    $display("reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_add_basic();
    int lat;
    run_op(16'h1234, 16'h0FCD, 1'b0, lat);
    check_res("add_1234_0fcd", 16'h2201, 1'b0, 1'b0);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles, required 5", lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got done=%b busy=%b one cycle later, required 0 0", done, busy);
    end
    checks++;
    if (result !== 16'h2201) begin
      errors++;
      $display("FAIL result_hold: got %h, required 2201", result);
    end
  endtask

  task automatic test_add_edges();
    int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    check_res("add_ffff_0001", 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    check_res("add_7fff_0001", 16'h8000, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    int lat;
    run_op(16'h0003, 16'h0005, 1'b1, lat);
    check_res("sub_0003_0005", 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, lat);
    check_res("sub_8000_0001", 16'h7FFF, 1'b1, 1'b1);
  endtask

  task automatic test_start_while_busy();
    int lat;
    @(negedge clk);
    start  = 1'b1;
    op_sub = 1'b0;
    a      = 16'h1111;
    b      = 16'h2222;
    lat    = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done) break;
      a = a + 16'h0101;
      b = b ^ 16'h5A5A;
      if (lat > 20) break;
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL busy_latency: got %0d cycles, required 5", lat);
    end
    check_res("busy_first_op", 16'h3333, 1'b0, 1'b0);
    // start still high: the next op is taken at the end of the following IDLE cycle.
    a = 16'h0005;
    b = 16'h0006;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got busy=%b, required 0", busy);
    end
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (done || lat > 20) break;
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL busy_second_latency: got %0d cycles, required 5", lat);
    end
    check_res("busy_second_op", 16'h000B, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    start  = 1'b1;
    op_sub = 1'b0;
    a      = 16'h1111;
    b      = 16'h1111;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    // idx = 2 now: two nibbles already written.
    checks++;
    if (result !== 16'h0022 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_partial: got result=%h busy=%b, required 0022 1", result, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, carry, overflow} !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: got busy=%b done=%b result=%h carry=%b ovf=%b, required all 0",
               busy, done, result, carry, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, lat);
    check_res("after_reset_op", 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa, xb, nxa, nxb;
    logic         xs, nxs;
    logic [W+1:0] exp;
    int           gap;
    xa = W'($urandom);
    xb = W'($urandom);
    xs = 1'($urandom_range(0, 1));
    @(negedge clk);
    start  = 1'b1;
    a      = xa;
    b      = xb;
    op_sub = xs;
    for (int k = 0; k < 1000; k++) begin
      gap = 0;
      while (1) begin
        @(negedge clk);
        gap++;
        if (done || gap > 20) break;
      end
      checks++;
      if (gap != ((k == 0) ? 5 : 6)) begin
        errors++;
        $display("FAIL b2b_gap: op %0d got %0d cycles, required %0d", k, gap, (k == 0) ? 5 : 6);
      end
      exp = model(xa, xb, xs);
      checks++;
      if (result !== exp[W-1:0] || carry !== exp[W+1] || overflow !== exp[W]) begin
        errors++;
        $display("FAIL b2b_result: op %0d %h %s %h got %h c=%b v=%b, required %h c=%b v=%b",
                 k, xa, xs ? "-" : "+", xb, result, carry, overflow,
                 exp[W-1:0], exp[W+1], exp[W]);
      end
      $display("b2b op %0d: %h %s %h = %h c=%b v=%b", k, xa, xs ? "-" : "+", xb,
               result, carry, overflow);
      nxa = W'($urandom);
      nxb = W'($urandom);
      nxs = 1'($urandom_range(0, 1));
      xa = nxa;
      xb = nxb;
      xs = nxs;
      a      = xa;
      b      = xb;
      op_sub = xs;
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    rst_n  = 1'b0;
    test_reset();
    test_add_basic();
    test_add_edges();
    test_sub();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
